// File: rtl/hawk_phase_scheduler_if.sv
// hawk_phase_scheduler_if: button inputs, controller status and scheduler
// outputs of the HAWK phase scheduler, bundled for a single port connection.
// slave  = the scheduler itself; master = whatever drives buttons/controller.
interface hawk_phase_scheduler_if;
  logic       btn_a;
  logic       btn_b;
  logic [3:0] present_state;
  logic       clr_count;
  logic       inc_count;
  logic       ctrl_tick;
  logic       YP;
  logic       NS;
  logic       flash_done;
  logic       req_pending;
  logic       chirp;

  modport slave (
    input  btn_a, btn_b, present_state, clr_count, inc_count,
    output ctrl_tick, YP, NS, flash_done, req_pending, chirp
  );

  modport master (
    output btn_a, btn_b, present_state, clr_count, inc_count,
    input  ctrl_tick, YP, NS, flash_done, req_pending, chirp
  );
endinterface

// File: rtl/hawk_phase_scheduler.sv
// hawk_phase_scheduler: tick prescaler, curb-button request arbitration,
// minimum-green enforcement and walk / flashing-clearance timing for the
// HAWK pedestrian-beacon controller.
// Optional build macro HAWK_SCHED_ACCESSIBLE_EN: long button presses extend
// the walk interval to twice WALK_TICKS and drive the audible chirp cue.
module hawk_phase_scheduler #(
  parameter int TICK_DIV         = 50000000,
  parameter int MIN_GREEN_TICKS  = 20,
  parameter int WALK_TICKS       = 7,
  parameter int FLASH_TICKS      = 10,
  parameter int LONG_PRESS_TICKS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  hawk_phase_scheduler_if.slave  bus
);

  localparam int DIV_W   = $clog2(TICK_DIV);
  localparam int GREEN_W = $clog2(MIN_GREEN_TICKS + 1);
`ifdef HAWK_SCHED_ACCESSIBLE_EN
  localparam int WALK_MAX = 2 * WALK_TICKS;
`else
  localparam int WALK_MAX = WALK_TICKS;
`endif
  localparam int WALK_W  = $clog2(WALK_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GRANT,
    S_BUSY
  } sched_state_e;

  // ---------------------------------------------------------------------
  // Prescaler and controller-state decodes
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;

  assign tick      = (div_cnt_q == DIV_W'(TICK_DIV - 1));
  assign div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);

  logic ps_green;   // vehicle green, including out-of-range codes
  logic ps_walk;
  logic ps_flash;

  assign ps_green = (bus.present_state == 4'd0) || (bus.present_state > 4'd13);
  assign ps_walk  = (bus.present_state == 4'd8);
  assign ps_flash = (bus.present_state == 4'd9);

  // ---------------------------------------------------------------------
  // Button synchronizers and merged rising-edge press
  // ---------------------------------------------------------------------
  logic [1:0] sync_a_q, sync_b_q;
  logic       prev_a_q, prev_b_q;
  logic       press_q;

  // Two-flop synchronizers, edge history and the registered merged press.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      prev_a_q <= 1'b0;
      prev_b_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[0], bus.btn_a};
      sync_b_q <= {sync_b_q[0], bus.btn_b};
      prev_a_q <= sync_a_q[1];
      prev_b_q <= sync_b_q[1];
      press_q  <= (sync_a_q[1] & ~prev_a_q) | (sync_b_q[1] & ~prev_b_q);
    end
  end

  // ---------------------------------------------------------------------
  // Interval counters
  // ---------------------------------------------------------------------
  logic [GREEN_W-1:0] green_cnt_q, green_cnt_d;
  logic [WALK_W-1:0]  walk_cnt_q, walk_cnt_d;
  logic [WALK_W-1:0]  walk_thr;
  logic [3:0]         flash_cnt_q, flash_cnt_d;
  logic               ns_q, ns_d;
  logic               flash_done_q, flash_done_d;
  logic               green_ok;

  assign green_ok = (green_cnt_q == GREEN_W'(MIN_GREEN_TICKS));

  // Next values of the green, walk and flash counters and their flags.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    green_cnt_d  = green_cnt_q;
    walk_cnt_d   = walk_cnt_q;
    flash_cnt_d  = flash_cnt_q;

    if (!ps_green)
      green_cnt_d = '0;
    else if (tick && !green_ok)
      green_cnt_d = green_cnt_q + GREEN_W'(1);

    if (!ps_walk)
      walk_cnt_d = '0;
    else if (tick && (walk_cnt_q != WALK_W'(WALK_MAX)))
      walk_cnt_d = walk_cnt_q + WALK_W'(1);

    // A clear in the same cycle as a tick wins.
    if (bus.clr_count || !ps_flash)
      flash_cnt_d = '0;
    else if (tick && bus.inc_count && (flash_cnt_q != 4'(FLASH_TICKS)))
      flash_cnt_d = flash_cnt_q + 4'd1;

    ns_d         = ps_walk && (walk_cnt_d >= walk_thr);
    flash_done_d = (flash_cnt_d == 4'(FLASH_TICKS));
  end

  // Prescaler, interval counters and the registered NS / flash_done flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= '0;
      green_cnt_q  <= '0;
      walk_cnt_q   <= '0;
      flash_cnt_q  <= '0;
      ns_q         <= 1'b0;
      flash_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      green_cnt_q  <= green_cnt_d;
      walk_cnt_q   <= walk_cnt_d;
      flash_cnt_q  <= flash_cnt_d;
      ns_q         <= ns_d;
      flash_done_q <= flash_done_d;
    end
  end

  // ---------------------------------------------------------------------
  // Request scheduler FSM
  // ---------------------------------------------------------------------
  sched_state_e state_q, state_d;
  logic         pend_q, pend_d;
  logic         yp, req_pending;

  // State and deferred-request flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Next state and Moore outputs; presses in HOLD/GRANT are absorbed.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    yp          = 1'b0;
    req_pending = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (press_q) state_d = S_HOLD;
      end
      S_HOLD: begin
        req_pending = 1'b1;
        if (green_ok) state_d = S_GRANT;
      end
      S_GRANT: begin
        yp          = 1'b1;
        req_pending = 1'b1;
        if (bus.present_state == 4'd1) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (press_q) pend_d = 1'b1;
        if (ps_green) begin
          state_d = (pend_q || press_q) ? S_HOLD : S_IDLE;
          pend_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Accessible long-press extension
  // ---------------------------------------------------------------------
`ifdef HAWK_SCHED_ACCESSIBLE_EN
  localparam int HOLD_W = $clog2(LONG_PRESS_TICKS + 1);

  logic [HOLD_W-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic              long_q, long_d;
  logic              was_walk_q;
  logic              long_hit;

  // Hold counters follow the synchronized level; long latches on the tick
  // a held button first reaches the threshold while a request is in flight.
  always_comb begin
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    if (!sync_a_q[1])
      hold_a_d = '0;
    else if (tick && (hold_a_q != HOLD_W'(LONG_PRESS_TICKS)))
      hold_a_d = hold_a_q + HOLD_W'(1);
    if (!sync_b_q[1])
      hold_b_d = '0;
    else if (tick && (hold_b_q != HOLD_W'(LONG_PRESS_TICKS)))
      hold_b_d = hold_b_q + HOLD_W'(1);

    long_hit = ((hold_a_d == HOLD_W'(LONG_PRESS_TICKS)) &&
                (hold_a_q != HOLD_W'(LONG_PRESS_TICKS))) ||
               ((hold_b_d == HOLD_W'(LONG_PRESS_TICKS)) &&
                (hold_b_q != HOLD_W'(LONG_PRESS_TICKS)));

    long_d = long_q;
    if (was_walk_q && !ps_walk)
      long_d = 1'b0;
    else if (long_hit && (state_q != S_IDLE))
      long_d = 1'b1;
  end

  // Hold counters, long flag and walk-exit history.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      long_q     <= 1'b0;
      was_walk_q <= 1'b0;
    end else begin
      hold_a_q   <= hold_a_d;
      hold_b_q   <= hold_b_d;
      long_q     <= long_d;
      was_walk_q <= ps_walk;
    end
  end

  assign walk_thr  = long_q ? WALK_W'(2 * WALK_TICKS) : WALK_W'(WALK_TICKS);
  assign bus.chirp = long_q && ps_walk;
`else
  // Long-press timing is not built; the parameter is kept for a uniform
  // interface across both build variants.
  logic [31:0] unused_long_press_cfg;
  assign unused_long_press_cfg = 32'(LONG_PRESS_TICKS);

  assign walk_thr  = WALK_W'(WALK_TICKS);
  assign bus.chirp = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.ctrl_tick   = tick;
  assign bus.YP          = yp;
  assign bus.NS          = ns_q;
  assign bus.flash_done  = flash_done_q;
  assign bus.req_pending = req_pending;

endmodule
